// File: rtl/ft245_pkg.sv
// Shared FT245 definitions: transmit FSM states, default strobe timing and pin polarities.
// Used by the transmit arbiter and the receive side.
package ft245_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } tx_state_e;

  localparam int DEF_SETUP_CYCLES   = 1;
  localparam int DEF_LOW_CYCLES     = 2;
  localparam int DEF_RECOVER_CYCLES = 1;

  localparam logic WR_IDLE   = 1'b1;
  localparam logic RD_IDLE   = 1'b1;
  localparam logic TXE_SPACE = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; 2-cycle latency, no backpressure.
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// Round-robin, packet-locked sharing of the FT245 transmit port between two byte requesters.
// One byte per SETUP+LOW+RECOVER+1 cycles; ready only asserts when the synchronized txe shows space.
module ft245_tx_arbiter
  import ft245_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int LOW_CYCLES     = DEF_LOW_CYCLES,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       txe,
  output logic       wr,
  output logic       rd,
  output logic [7:0] data_out,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int MAXC = max3(SETUP_CYCLES, LOW_CYCLES, RECOVER_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  tx_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lock;
  logic          last_served;
  logic          txe_s;
  logic          sel1;
  logic          sel_valid;
  logic          sel_last;
  logic          accept;

  sync_2ff #(.RST_VAL(1'b1)) u_txe_sync (
    .clk   (clk),
    .rst_n (reset_in),
    .d     (txe),
    .q     (txe_s)
  );

  // A locked packet owner is the only candidate; otherwise alternate when both contend.
  always_comb begin
    sel1 = 1'b0;
    if (lock) begin
      sel1 = grant[1];
    end else if (req0_valid && req1_valid) begin
      sel1 = ~last_served;
    end else begin
      sel1 = req1_valid;
    end
  end

  assign sel_valid  = sel1 ? req1_valid : req0_valid;
  assign sel_last   = sel1 ? req1_last  : req0_last;
  assign accept     = (state == IDLE) && (txe_s == TXE_SPACE) && sel_valid;
  assign req0_ready = accept && !sel1;
  assign req1_ready = accept && sel1;
  assign busy       = (state != IDLE);
  assign rd         = RD_IDLE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = CW'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CW'(LOW_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = RECOVER;
          cnt_nxt   = CW'(RECOVER_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // wr is registered from the next state so the pin is driven straight from a flop.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= 8'h00;
      grant       <= 2'b00;
      lock        <= 1'b0;
      last_served <= 1'b1;
      wr          <= WR_IDLE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wr    <= (state_nxt == STROBE) ? ~WR_IDLE : WR_IDLE;
      if (accept) begin
        data_out    <= sel1 ? req1_data : req0_data;
        grant       <= sel1 ? 2'b10 : 2'b01;
        lock        <= ~sel_last;
        last_served <= sel1;
      end else if ((state == RECOVER) && (state_nxt == IDLE) && !lock) begin
        grant <= 2'b00;
      end
    end
  end

endmodule

// File: doc/ft245_tx_arbiter.md
Name: ft245_tx_arbiter

Overview:
- Shares the FT245-style transmit FIFO port (txe/wr/data_out) between two byte-stream requesters using round-robin arbitration.
- A requester keeps the grant until its packet ends.
- Sequences each byte write with programmable setup, strobe and recovery phases.
- Sits between on-chip byte sources and the external USB FIFO pins; the port is transmit-only, so rd is held inactive.

Parameters:
- SETUP_CYCLES, 1: cycles data_out is stable before wr falls; must be >= 1.
- LOW_CYCLES, 2: cycles wr is held low; the falling edge commits the byte; must be >= 1.
- RECOVER_CYCLES, 1: cycles wr is held high after the strobe before the next accept; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_in  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  byte is the last of the req0 packet.
- req0_ready  out  1  req0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  8  requester 1 byte.
- req1_last  in  1  byte is the last of the req1 packet.
- req1_ready  out  1  req1 byte accepted this cycle.
- txe  in  1  device FIFO full flag, asynchronous; low = space available.
- wr  out  1  write strobe; idles high; falling edge writes.
- rd  out  1  read strobe; constant 1.
- data_out  out  8  byte to device.
- grant  out  2  one-hot current owner; 00 when none.
- busy  out  1  high when state != IDLE.

Behaviour:
- txe passes through a 2-flop synchronizer; txe_s is the synchronized value, 2-cycle latency.
- Reset (asynchronous, reset_in=0):
  - wr=1, rd=1, data_out=0, req*_ready=0, grant=00, busy=0.
  - state=IDLE, lock cleared, rr pointer favours req0 first, synchronizer flops=1 (full).
  - Reset asserted mid-write forces wr high immediately; the byte in flight is abandoned.
- FSM states: IDLE, SETUP, STROBE, RECOVER; the phase counter is sized for the largest parameter.
- IDLE, selection:
  - If lock is set, the locked requester is the only candidate.
  - Otherwise, if exactly one requester is valid, it is selected.
  - If both are valid, the requester not served last is selected and the rr pointer toggles on accept.
- IDLE, accept:
  - Accept occurs when txe_s==0 and the selected requester is valid.
  - reqN_ready is combinational, high only in that cycle (single-cycle valid/ready handshake).
  - On accept: data_out<=reqN_data, grant<=one-hot N, lock<=~reqN_last, state<=SETUP, counter loaded.
- SETUP: wr=1 for SETUP_CYCLES, then STROBE.
- STROBE: wr=0 for LOW_CYCLES, then RECOVER.
- RECOVER: wr=1 for RECOVER_CYCLES, then IDLE. If lock==0, grant<=00 on entry to IDLE.
- Timing: accept in cycle N means data_out is valid at N+1, wr falls at N+1+S, wr rises at N+1+S+L, and the next accept is possible at N+1+S+L+R at the earliest. With defaults, that is one byte per 5 cycles.
- data_out is held constant from SETUP through RECOVER. It also holds its last value in IDLE and never glitches.
- txe going high after accept does not abort the byte; the cycle completes. No new accept occurs while txe_s==1.
- While locked and the owner deasserts valid, the arbiter waits in IDLE with grant held. The other requester is starved until the owner's last byte is accepted; this is intentional packet atomicity.
- A req_valid with no txe space produces no ready. Requesters must hold data stable while valid is high.
- rd is tied high at all times and is not affected by reset.

Decomposition:
- Shared package ft245_pkg:
  - state enum (IDLE/SETUP/STROBE/RECOVER).
  - default timing constants.
  - FT245 pin polarity constants (WR_IDLE=1, TXE_SPACE=0).
- One sub-module, sync_2ff: 2-flop synchronizer with async active-low reset and a reset-value parameter. It is used for txe here and reused by the receive side.
- Arbitration, FSM and counter stay in ft245_tx_arbiter.

Test Plan:
1. Reset then idle: reset_in=0 mid-STROBE -> wr=1 immediately. After release: grant=00, busy=0, data_out=00, rd=1.
2. Single byte, req0_data=8'hA5, last=1, txe=0 (defaults): req0_ready for one cycle at N, data_out=A5 at N+1, wr low at N+2..N+3, IDLE at N+5, grant=00.
3. Round-robin, both valid with last=1, req0=8'h11, req1=8'h22, txe=0 -> device sees 11,22,11,22 on successive wr falling edges.
4. Packet lock: req0 sends 3 bytes (01,02,03; last on 03) while req1 is valid with 8'hFF -> order 01,02,03,FF. grant=01 throughout the req0 packet.
5. FIFO full: txe=1 with req1 valid -> no ready, wr stays high. txe falls at T -> req1_ready at T+2 (sync latency).
6. txe rises during STROBE -> the strobe completes its full LOW_CYCLES; no further accept until txe_s returns to 0.
